// File: rtl/clk_rst_seq_pkg.sv
// Shared types and default constants for the clock/reset sequencer.
//   clk_rst_seq_state_t : sequencer FSM state encoding
//   *_DEF               : default parameter values used by the sequencer blocks
package clk_rst_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    HOLD,
    RELEASE,
    RUN,
    STOP
  } clk_rst_seq_state_t;

  localparam int unsigned NUM_DOMAINS_DEF   = 4;
  localparam int unsigned CNT_W_DEF         = 16;
  localparam int unsigned SETTLE_CYCLES_DEF = 8;

endpackage

// File: rtl/clk_rst_seq_cnt.sv
// Loadable down-counter that stops at zero.
//   clk      : clock
//   reset    : synchronous active-high reset (count -> 0)
//   load     : load load_val this cycle (wins over dec)
//   load_val : value to load
//   dec      : decrement request; ignored once the count is 0
//   zero     : count currently equals 0
module clk_rst_seq_cnt
  import clk_rst_seq_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/clk_rst_sequencer.sv
// Power-up/reset sequencer: enables the selected domain clocks, lets them
// settle with resets held, holds reset for a configurable time, then releases
// the domain resets one by one in ascending index order.
//   clk, reset     : clock, synchronous active-high reset
//   start_req      : start request (looked at only in IDLE)
//   start_ack      : one-cycle pulse when a start is accepted
//   stop_req       : stop request (looked at only in RUN, highest priority)
//   soft_rst_req   : re-run hold/release with the captured config (RUN only)
//   domain_mask    : domains to sequence, captured on start accept
//   assert_cycles  : reset hold length, 0 behaves as 1
//   gap_cycles     : extra cycles between successive releases
//   clk_en         : per-domain clock enable
//   domain_rst     : per-domain active-high reset
//   busy           : high in SETTLE, HOLD, RELEASE and STOP
//   done           : one-cycle pulse on entry to RUN
module clk_rst_sequencer
  import clk_rst_seq_pkg::*;
#(
  parameter int unsigned NUM_DOMAINS   = NUM_DOMAINS_DEF,
  parameter int unsigned CNT_W         = CNT_W_DEF,
  parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_req,
  output logic                   start_ack,
  input  logic                   stop_req,
  input  logic                   soft_rst_req,
  input  logic [NUM_DOMAINS-1:0] domain_mask,
  input  logic [CNT_W-1:0]       assert_cycles,
  input  logic [CNT_W-1:0]       gap_cycles,
  output logic [NUM_DOMAINS-1:0] clk_en,
  output logic [NUM_DOMAINS-1:0] domain_rst,
  output logic                   busy,
  output logic                   done
);

  // Wide enough to hold NUM_DOMAINS, i.e. "past the last domain".
  localparam int unsigned IDX_W = $clog2(NUM_DOMAINS + 1);

  clk_rst_seq_state_t state_q, state_d;

  logic [NUM_DOMAINS-1:0] mask_q, mask_d;
  logic [NUM_DOMAINS-1:0] clk_en_q, clk_en_d;
  logic [NUM_DOMAINS-1:0] domain_rst_q, domain_rst_d;
  logic [NUM_DOMAINS-1:0] rel_onehot;
  logic [CNT_W-1:0]       assert_q, assert_d;
  logic [CNT_W-1:0]       gap_q, gap_d;
  logic [CNT_W-1:0]       hold_len, cnt_load_val;
  logic [IDX_W-1:0]       rel_idx_q, rel_idx_d;
  logic [IDX_W-1:0]       search_start, found_idx;
  logic                   found, cnt_load, cnt_dec, cnt_zero;
  logic                   start_ack_q, start_ack_d;
  logic                   done_q, done_d;
  logic                   busy_q, busy_d;

  // Counter load value for HOLD: max(assert,1)-1.
  assign hold_len = (assert_q == '0) ? '0 : assert_q - CNT_W'(1);

  // On the HOLD->RELEASE edge the search restarts from domain 0; inside
  // RELEASE it continues from the slot after the last released domain.
  assign search_start = (state_q == HOLD) ? '0 : rel_idx_q;

  // Lowest set bit of the captured mask at or above search_start.
  always_comb begin
    found     = 1'b0;
    found_idx = '0;
    for (int i = NUM_DOMAINS - 1; i >= 0; i--) begin
      if (mask_q[i] && (IDX_W'(i) >= search_start)) begin
        found     = 1'b1;
        found_idx = IDX_W'(i);
      end
    end
  end

  for (genvar gi = 0; gi < NUM_DOMAINS; gi++) begin : g_rel_onehot
    assign rel_onehot[gi] = (found_idx == IDX_W'(gi));
  end

  assign cnt_dec = (state_q == SETTLE) || (state_q == HOLD) || (state_q == RELEASE);

  clk_rst_seq_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    assert_d     = assert_q;
    gap_d        = gap_q;
    clk_en_d     = clk_en_q;
    domain_rst_d = domain_rst_q;
    rel_idx_d    = rel_idx_q;
    start_ack_d  = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;

    unique case (state_q)
      IDLE: begin
        if (start_req) begin
          start_ack_d = 1'b1;
          mask_d      = domain_mask;
          assert_d    = assert_cycles;
          gap_d       = gap_cycles;
          clk_en_d    = domain_mask;
          rel_idx_d   = '0;
          if (domain_mask == '0) begin
            state_d = RUN;
          end else begin
            state_d      = SETTLE;
            cnt_load     = 1'b1;
            cnt_load_val = CNT_W'(SETTLE_CYCLES - 1);
          end
        end
      end
      SETTLE: begin
        if (cnt_zero) begin
          state_d      = HOLD;
          cnt_load     = 1'b1;
          cnt_load_val = hold_len;
        end
      end
      HOLD: begin
        if (cnt_zero) begin
          // The first release lands on the same edge that enters RELEASE.
          state_d = RELEASE;
          if (found) begin
            domain_rst_d = domain_rst_q & ~rel_onehot;
            rel_idx_d    = found_idx + IDX_W'(1);
            cnt_load     = 1'b1;
            cnt_load_val = gap_q;
          end
        end
      end
      RELEASE: begin
        // Leaving does not wait for the gap timer after the last release.
        if (!found) begin
          state_d = RUN;
        end else if (cnt_zero) begin
          domain_rst_d = domain_rst_q & ~rel_onehot;
          rel_idx_d    = found_idx + IDX_W'(1);
          cnt_load     = 1'b1;
          cnt_load_val = gap_q;
        end
      end
      RUN: begin
        if (stop_req) begin
          state_d      = STOP;
          domain_rst_d = '1;
        end else if (soft_rst_req) begin
          state_d      = HOLD;
          domain_rst_d = '1;
          cnt_load     = 1'b1;
          cnt_load_val = hold_len;
        end
      end
      STOP: begin
        // Resets went high one edge earlier; clocks stop now.
        state_d  = IDLE;
        clk_en_d = '0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign done_d = (state_d == RUN) && (state_q != RUN);
  assign busy_d = (state_d == SETTLE) || (state_d == HOLD) ||
                  (state_d == RELEASE) || (state_d == STOP);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      mask_q       <= '0;
      assert_q     <= '0;
      gap_q        <= '0;
      clk_en_q     <= '0;
      domain_rst_q <= '1;
      rel_idx_q    <= '0;
      start_ack_q  <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      assert_q     <= assert_d;
      gap_q        <= gap_d;
      clk_en_q     <= clk_en_d;
      domain_rst_q <= domain_rst_d;
      rel_idx_q    <= rel_idx_d;
      start_ack_q  <= start_ack_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
    end
  end

  assign clk_en     = clk_en_q;
  assign domain_rst = domain_rst_q;
  assign start_ack  = start_ack_q;
  assign done       = done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_clk_rst_sequencer.sv
// Directed bench for clk_rst_sequencer: a per-cycle vector table for the
// basic start sequence plus hand-written multi-cycle corner cases.
module tb_clk_rst_sequencer;

  logic        clk = 1'b0;
  logic        reset, start_req, stop_req, soft_rst_req;
  logic [3:0]  domain_mask;
  logic [15:0] assert_cycles, gap_cycles;
  logic        start_ack, done, busy;
  logic [3:0]  clk_en, domain_rst;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  clk_rst_sequencer #(
    .NUM_DOMAINS   (4),
    .CNT_W         (16),
    .SETTLE_CYCLES (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start_req     (start_req),
    .start_ack     (start_ack),
    .stop_req      (stop_req),
    .soft_rst_req  (soft_rst_req),
    .domain_mask   (domain_mask),
    .assert_cycles (assert_cycles),
    .gap_cycles    (gap_cycles),
    .clk_en        (clk_en),
    .domain_rst    (domain_rst),
    .busy          (busy),
    .done          (done)
  );

  // Row k: start_req driven before edge T+k, outputs expected after edge T+k.
  typedef struct {
    logic       start;
    logic [3:0] en;
    logic [3:0] rst;
    logic       ack;
    logic       dn;
    logic       bsy;
  } vec_t;

  vec_t tbl [1:20];

  function automatic vec_t mk(logic s, logic [3:0] en, logic [3:0] rst,
                              logic a, logic d, logic b);
    vec_t v;
    v.start = s; v.en = en; v.rst = rst; v.ack = a; v.dn = d; v.bsy = b;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Basic sequence: mask 1011, assert 3, gap 2.
  task automatic run_table(input string tag);
    domain_mask   = 4'b1011;
    assert_cycles = 16'd3;
    gap_cycles    = 16'd2;
    for (int k = 1; k <= 20; k++) begin
      start_req = tbl[k].start;
      step();
      $display("%s k=%0d en=%b rst=%b ack=%b done=%b busy=%b", tag, k,
               clk_en, domain_rst, start_ack, done, busy);
      chk($sformatf("%s en/rst k=%0d", tag, k), {24'd0, clk_en, domain_rst},
          {24'd0, tbl[k].en, tbl[k].rst});
      chk($sformatf("%s ack/done/busy k=%0d", tag, k), {29'd0, start_ack, done, busy},
          {29'd0, tbl[k].ack, tbl[k].dn, tbl[k].bsy});
    end
    start_req = 1'b0;
  endtask

  // From RUN: stop, then one more edge to reach IDLE.
  task automatic do_stop(input string tag);
    stop_req = 1'b1;
    step();
    stop_req = 1'b0;
    chk({tag, " stop rst"}, {28'd0, domain_rst}, 32'hF);
    step();
    chk({tag, " stop idle en/busy"}, {27'd0, clk_en, busy}, 32'd0);
    $display("%s stop done en=%b rst=%b busy=%b", tag, clk_en, domain_rst, busy);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int k;
    int seen;
    logic [3:0] exp2 [9:14];

    tbl[1] = mk(1, 4'b1011, 4'b1111, 1, 0, 1);
    for (int j = 2; j <= 11; j++) tbl[j] = mk(0, 4'b1011, 4'b1111, 0, 0, 1);
    tbl[12] = mk(0, 4'b1011, 4'b1110, 0, 0, 1);
    tbl[13] = mk(0, 4'b1011, 4'b1110, 0, 0, 1);
    tbl[14] = mk(0, 4'b1011, 4'b1110, 0, 0, 1);
    tbl[15] = mk(0, 4'b1011, 4'b1100, 0, 0, 1);
    tbl[16] = mk(0, 4'b1011, 4'b1100, 0, 0, 1);
    tbl[17] = mk(0, 4'b1011, 4'b1100, 0, 0, 1);
    tbl[18] = mk(0, 4'b1011, 4'b0100, 0, 0, 1);
    tbl[19] = mk(0, 4'b1011, 4'b0100, 0, 1, 0);
    tbl[20] = mk(0, 4'b1011, 4'b0100, 0, 0, 0);

    exp2[9]  = 4'b1111;
    exp2[10] = 4'b1110;
    exp2[11] = 4'b1100;
    exp2[12] = 4'b1000;
    exp2[13] = 4'b0000;
    exp2[14] = 4'b0000;

    reset = 1'b1; start_req = 1'b0; stop_req = 1'b0; soft_rst_req = 1'b0;
    domain_mask = 4'b0; assert_cycles = 16'd0; gap_cycles = 16'd0;
    @(negedge clk);
    step(); step(); step();
    chk("reset en/rst", {24'd0, clk_en, domain_rst}, {24'd0, 4'b0000, 4'b1111});
    chk("reset ack/done/busy", {29'd0, start_ack, done, busy}, 32'd0);
    $display("reset en=%b rst=%b ack=%b done=%b busy=%b", clk_en, domain_rst, start_ack, done, busy);
    reset = 1'b0;
    step();

    // Test 1: table-driven start sequence.
    run_table("t1");

    // Test 3: soft reset from RUN repeats hold/release with captured config.
    soft_rst_req = 1'b1;
    step();
    soft_rst_req = 1'b0;
    chk("t3 soft en/rst", {24'd0, clk_en, domain_rst}, {24'd0, 4'b1011, 4'b1111});
    chk("t3 soft busy/done", {30'd0, busy, done}, {30'd0, 1'b1, 1'b0});
    k = 1;
    while (!done && k < 40) begin
      step();
      k++;
    end
    chk("t3 done cycle", k, 11);
    chk("t3 done en/rst", {24'd0, clk_en, domain_rst}, {24'd0, 4'b1011, 4'b0100});
    $display("t3 soft reset done at k=%0d rst=%b", k, domain_rst);

    // Test 4: stop and soft reset together, stop wins.
    stop_req = 1'b1; soft_rst_req = 1'b1;
    step();
    stop_req = 1'b0; soft_rst_req = 1'b0;
    chk("t4 k1 en/rst", {24'd0, clk_en, domain_rst}, {24'd0, 4'b1011, 4'b1111});
    chk("t4 k1 busy", {31'd0, busy}, 32'd1);
    step();
    chk("t4 k2 en/rst", {24'd0, clk_en, domain_rst}, {24'd0, 4'b0000, 4'b1111});
    chk("t4 k2 busy", {31'd0, busy}, 32'd0);
    step();
    chk("t4 k3 busy/done/ack", {29'd0, busy, done, start_ack}, 32'd0);
    $display("t4 stop en=%b rst=%b busy=%b", clk_en, domain_rst, busy);

    // Test 2: mask 1111, assert 0, gap 0.
    domain_mask = 4'b1111; assert_cycles = 16'd0; gap_cycles = 16'd0;
    start_req = 1'b1;
    step();
    start_req = 1'b0;
    chk("t2 k1 ack/en", {27'd0, start_ack, clk_en}, {27'd0, 1'b1, 4'b1111});
    for (int j = 2; j <= 15; j++) begin
      step();
      if (j >= 9 && j <= 14) begin
        chk($sformatf("t2 rst k=%0d", j), {28'd0, domain_rst}, {28'd0, exp2[j]});
      end
      if (j == 9)  chk("t2 hold busy", {31'd0, busy}, 32'd1);
      if (j == 13) chk("t2 no early done", {31'd0, done}, 32'd0);
      if (j == 14) chk("t2 done", {31'd0, done}, 32'd1);
      if (j == 15) chk("t2 done pulse width", {31'd0, done}, 32'd0);
      $display("t2 k=%0d rst=%b done=%b busy=%b", j, domain_rst, done, busy);
    end
    do_stop("t2");

    // Test 5: reset during RELEASE, then a fresh start.
    domain_mask = 4'b1011; assert_cycles = 16'd3; gap_cycles = 16'd2;
    start_req = 1'b1;
    step();
    start_req = 1'b0;
    for (int j = 2; j <= 12; j++) step();
    chk("t5 rst before reset", {28'd0, domain_rst}, 32'hE);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t5 after reset en/rst", {24'd0, clk_en, domain_rst}, {24'd0, 4'b0000, 4'b1111});
    chk("t5 after reset done/busy/ack", {29'd0, done, busy, start_ack}, 32'd0);
    seen = 0;
    for (int j = 0; j < 25; j++) begin
      step();
      if (done || busy) seen++;
    end
    chk("t5 idle after reset", seen, 0);
    $display("t5 mid-release reset en=%b rst=%b", clk_en, domain_rst);
    run_table("t5");
    do_stop("t5");

    // Test 6: empty mask, then a start_req pulse inside SETTLE.
    domain_mask = 4'b0000;
    start_req = 1'b1;
    step();
    start_req = 1'b0;
    chk("t6 empty ack/done", {30'd0, start_ack, done}, {30'd0, 2'b11});
    chk("t6 empty en/busy", {27'd0, clk_en, busy}, 32'd0);
    step();
    chk("t6 empty pulses end", {30'd0, start_ack, done}, 32'd0);
    do_stop("t6");
    domain_mask = 4'b1111; assert_cycles = 16'd3; gap_cycles = 16'd2;
    start_req = 1'b1;
    step();
    start_req = 1'b0;
    chk("t6 first ack", {31'd0, start_ack}, 32'd1);
    seen = 0;
    for (int j = 2; j <= 8; j++) begin
      start_req = (j == 3);
      step();
      if (start_ack) seen++;
    end
    start_req = 1'b0;
    chk("t6 no second ack", seen, 0);
    chk("t6 settle en/busy", {27'd0, clk_en, busy}, {27'd0, 4'b1111, 1'b1});
    $display("t6 settle start pulse acks=%0d en=%b busy=%b", seen, clk_en, busy);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
